// File: rtl/mem_pkg.sv
// Shared types and widths for the memory stage: FSM states, datapath widths
// and the writeback-enable gating rule.
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Register x0 is hard-wired, so a write to it is never enabled.
    function automatic logic gate_wb_en(input logic en, input logic [REG_ADDR_W-1:0] rd);
        return en && (rd != '0);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles spent waiting for dmem_ready; expired marks the cycle
// whose missing ready would bring the count to TIMEOUT_CYCLES.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through in one cycle, performs
// aligned word loads/stores over a ready/valid-style bus with a wait timeout.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_res,
    input  logic                  ex_write_reg,
    input  logic                  ex_load_en,
    input  logic                  ex_store_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic                  mem_stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  err
);

    state_t state, state_nxt;

    logic                  is_mem, bad_op, accept, done_ok, abort, expired;
    logic [DATA_W-1:2]     addr_p1;
    logic [DATA_W-1:0]     wdata_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic                  wreg_p1, we_p1;

    logic                  wb_valid_nxt, wb_en_nxt, err_nxt;
    logic [REG_ADDR_W-1:0] wb_rd_nxt;
    logic [DATA_W-1:0]     wb_data_nxt;

    assign is_mem  = ex_load_en | ex_store_en;
    assign bad_op  = (ex_load_en & ex_store_en) | (is_mem & (ex_res[1:0] != 2'b00));
    assign accept  = (state == IDLE) && ex_valid && is_mem && !bad_op;
    // Ready wins over the timeout when both land in the same cycle.
    assign done_ok = (state == ACCESS) && dmem_ready;
    assign abort   = (state == ACCESS) && !dmem_ready && expired;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable ((state == ACCESS) && !dmem_ready),
        .expired(expired)
    );

    // Stage p1: request fields captured on accept, held through ACCESS.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= ex_res[DATA_W-1:2];
            wdata_p1 <= ex_store_data;
            rd_p1    <= ex_rd;
            wreg_p1  <= ex_write_reg;
            we_p1    <= ex_store_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  if (done_ok || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_stall  = (state == ACCESS);
        dmem_req   = (state == ACCESS);
        dmem_we    = (state == ACCESS) && we_p1;
        dmem_addr  = (state == ACCESS) ? {addr_p1, 2'b00} : '0;
        dmem_wdata = (state == ACCESS) ? wdata_p1 : '0;
    end

    always_comb begin
        wb_valid_nxt = 1'b0;
        wb_en_nxt    = 1'b0;
        err_nxt      = 1'b0;
        wb_rd_nxt    = '0;
        wb_data_nxt  = '0;
        if ((state == IDLE) && ex_valid && !accept) begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = ex_rd;
            if (bad_op) begin
                err_nxt = 1'b1;
            end else begin
                wb_data_nxt = ex_res;
                wb_en_nxt   = gate_wb_en(ex_write_reg, ex_rd);
            end
        end else if (done_ok) begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = rd_p1;
            if (!we_p1) begin
                wb_data_nxt = dmem_rdata;
                wb_en_nxt   = gate_wb_en(wreg_p1, rd_p1);
            end
        end else if (abort) begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = rd_p1;
            err_nxt      = 1'b1;
        end
    end

    // Stage p2: registered writeback and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= wb_valid_nxt;
            wb_en    <= wb_en_nxt;
            wb_rd    <= wb_rd_nxt;
            wb_data  <= wb_data_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; each instruction's outcome is
// predicted from the stage's behavioural rules (latency, alignment, timeout).
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_write_reg, ex_load_en, ex_store_en;
    logic [31:0] ex_res, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_en, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_total = 0;
    int n_pass  = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_res       (ex_res),
        .ex_write_reg (ex_write_reg),
        .ex_load_en   (ex_load_en),
        .ex_store_en  (ex_store_en),
        .ex_rd        (ex_rd),
        .ex_store_data(ex_store_data),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, mem_stall, 0);
        chk({tag, "_req"},   dmem_req, 0);
        chk({tag, "_we"},    dmem_we, 0);
        chk({tag, "_addr"},  dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_wbv"},   wb_valid, 0);
        chk({tag, "_wben"},  wb_en, 0);
        chk({tag, "_wbrd"},  wb_rd, 0);
        chk({tag, "_wbd"},   wb_data, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    // Called at a falling edge with the stage idle. lat = ACCESS cycle in which
    // ready is given (1 = first), 0 = never.
    task automatic run_instr(input logic v, input logic ld, input logic st, input logic wr,
                             input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                             input int lat, input logic [31:0] rdata);
        bit is_mem, bad, ok;
        int n;
        is_mem = ld || st;
        bad    = (ld && st) || (is_mem && res[1:0] != 2'b00);
        ex_valid = v; ex_load_en = ld; ex_store_en = st; ex_write_reg = wr;
        ex_res = res; ex_store_data = sd; ex_rd = rd;
        dmem_ready = 1'b0;
        @(negedge clk);
        if (!v) begin
            chk("idle_wbv", wb_valid, 0);
            chk("idle_err", err, 0);
            chk("idle_req", dmem_req, 0);
            return;
        end
        if (bad) begin
            chk("bad_req", dmem_req, 0);
            chk("bad_stall", mem_stall, 0);
            chk("bad_err", err, 1);
            chk("bad_wbv", wb_valid, 1);
            chk("bad_wben", wb_en, 0);
            return;
        end
        if (!is_mem) begin
            chk("alu_wbv", wb_valid, 1);
            chk("alu_data", wb_data, res);
            chk("alu_rd", wb_rd, rd);
            chk("alu_wben", wb_en, wr && rd != 0);
            chk("alu_stall", mem_stall, 0);
            chk("alu_err", err, 0);
            return;
        end
        ok = (lat >= 1) && (lat <= T);
        n  = ok ? lat : T;
        for (int k = 1; k <= n; k++) begin
            ex_valid = 1'($urandom); ex_load_en = 1'($urandom); ex_store_en = 1'($urandom);
            ex_write_reg = 1'($urandom); ex_res = $urandom; ex_store_data = $urandom;
            ex_rd = 5'($urandom);
            dmem_ready = ok && (k == lat);
            dmem_rdata = (k == lat) ? rdata : $urandom;
            chk("acc_stall", mem_stall, 1);
            chk("acc_req", dmem_req, 1);
            chk("acc_addr", dmem_addr, {res[31:2], 2'b00});
            chk("acc_we", dmem_we, st);
            chk("acc_wdata", dmem_wdata, sd);
            chk("acc_wbv", wb_valid, 0);
            chk("acc_err", err, 0);
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        ex_valid = 1'b0;
        chk("end_stall", mem_stall, 0);
        chk("end_req", dmem_req, 0);
        chk("end_wbv", wb_valid, 1);
        chk("end_rd", wb_rd, rd);
        chk("end_err", err, !ok);
        chk("end_wben", wb_en, ok && ld && wr && rd != 0);
        if (ok) chk("end_data", wb_data, ld ? rdata : 32'h0);
    endtask

    initial begin
        int kind, lat;
        logic [31:0] a;
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_load_en = 1'b0; ex_store_en = 1'b0; ex_write_reg = 1'b1;
        ex_res = 32'h55; ex_store_data = 32'h0; ex_rd = 5'd1;
        dmem_ready = 1'b1; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        ex_valid = 1'b0; dmem_ready = 1'b0;
        rst_n = 1'b1;

        run_instr(1, 0, 0, 1, 32'h0000_0011, 0, 5'd5, 0, 0);
        run_instr(1, 1, 0, 1, 32'h0000_0100, 32'h77, 5'd3, 3, 32'hDEAD_BEEF);
        run_instr(1, 0, 1, 0, 32'h0000_0204, 32'h1234, 5'd7, 1, 0);
        run_instr(1, 1, 0, 1, 32'h0000_0102, 0, 5'd3, 1, 0);
        run_instr(1, 1, 0, 1, 32'h0000_0300, 0, 5'd0, 1, 32'hCAFE_F00D);
        run_instr(1, 1, 0, 1, 32'h0000_0400, 0, 5'd9, 0, 0);
        run_instr(1, 1, 0, 1, 32'h0000_0404, 0, 5'd9, T, 32'h0BAD_F00D);
        run_instr(1, 0, 1, 1, 32'h0000_0408, 32'h99, 5'd4, T + 1, 0);
        run_instr(1, 1, 1, 1, 32'h0000_0500, 0, 5'd2, 1, 0);
        run_instr(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 5'd31, 0, 0);
        run_instr(1, 0, 0, 1, 32'h8000_0003, 0, 5'd0, 0, 0);
        run_instr(1, 0, 0, 0, 32'h1234_5678, 0, 5'd8, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a load: everything drops immediately.
        ex_valid = 1'b1; ex_load_en = 1'b1; ex_store_en = 1'b0; ex_write_reg = 1'b1;
        ex_res = 32'h0000_0600; ex_rd = 5'd6;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("mid_stall", mem_stall, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wbv", wb_valid, 0);
        chk("post_rst_stall", mem_stall, 0);
        run_instr(1, 0, 0, 1, 32'h0000_0011, 0, 5'd5, 0, 0);

        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            lat  = $urandom_range(0, T + 2);
            a    = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            case (kind)
                0, 1, 2, 3: run_instr(1, 0, 0, 1'($urandom), $urandom, $urandom, 5'($urandom), 0, 0);
                4, 5:       run_instr(1, 1, 0, 1'($urandom), a, $urandom, 5'($urandom), lat, $urandom);
                6, 7:       run_instr(1, 0, 1, 1'($urandom), a, $urandom, 5'($urandom), lat, $urandom);
                8:          run_instr(1, 1'($urandom), 1'($urandom) | 1'b1, 1'($urandom),
                                      a | 32'($urandom_range(1, 3)), $urandom, 5'($urandom), lat, 0);
                default:    run_instr(1'($urandom), 1, 1, 1, a, $urandom, 5'($urandom), lat, 0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS cycles waited for dmem_ready before abort.
REQ-002 SHALL use one clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports ex_valid in 1, ex_res in 32, ex_write_reg in 1, ex_load_en in 1, ex_store_en in 1, ex_rd in 5, ex_store_data in 32.
- ex_valid: execute output valid this cycle.
- ex_res: ALU result, or byte address for loads/stores.
- ex_write_reg, ex_load_en, ex_store_en: execute controls.
- ex_rd: destination register.
- ex_store_data: SW data.
REQ-004 SHALL have output mem_stall, 1 bit: upstream holds its outputs stable while high.
REQ-005 SHALL have these data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_ready in 1, dmem_rdata in 32.
REQ-006 SHALL have these writeback ports: wb_valid out 1, wb_en out 1, wb_rd out 5, wb_data out 32, err out 1 (one-cycle error pulse).

Function
REQ-007 SHALL implement FSM states IDLE and ACCESS; mem_stall is 1 exactly when the state is ACCESS (registered).
REQ-008 In IDLE, an edge with ex_valid=1 and load_en=store_en=0 SHALL register wb_valid=1, wb_data=ex_res, wb_rd=ex_rd, wb_en=ex_write_reg, giving 1-cycle latency; otherwise wb_valid=0 next cycle.
REQ-009 In IDLE, ex_valid=1 with exactly one of load_en/store_en set and ex_res[1:0]=0 SHALL latch address, rd, write_reg, we and store data, then enter ACCESS.
REQ-010 In ACCESS:
- dmem_req=1.
- dmem_addr={addr[31:2],2'b00}.
- dmem_we=1 for store, else 0.
- dmem_wdata=latched store data.
- All four stay stable until ready or abort.
REQ-011 In ACCESS, dmem_ready sampled 1 SHALL return the FSM to IDLE at that edge and register wb_valid=1, wb_rd=latched rd.
- Load: wb_data=dmem_rdata, wb_en=latched write_reg.
- Store: wb_en=0, wb_data=0.
REQ-012 Minimum memory latency SHALL be 2 cycles (accept edge, ready in first ACCESS cycle); mem_stall drops on the completing edge.
REQ-013 ex_valid and ex_* inputs SHALL be ignored while in ACCESS.
REQ-014 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ready. On reaching TIMEOUT_CYCLES the block SHALL:
- drop dmem_req next cycle and return to IDLE;
- pulse err for one cycle;
- assert wb_valid=1 with wb_en=0.
REQ-015 ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success; no err.
REQ-016 A misaligned access (ex_res[1:0]!=0), or load_en=store_en=1, SHALL cause no memory request, stay in IDLE, and next cycle give err=1, wb_valid=1, wb_en=0.
REQ-017 wb_en SHALL be forced 0 whenever wb_rd=0.
REQ-018 wb_valid and err SHALL be single-cycle pulses per instruction; back-to-back non-memory ops SHALL produce one wb_valid per cycle.

Reset
REQ-019 While rst_n=0, the FSM SHALL be in IDLE and the wait counter SHALL be 0.
REQ-020 While rst_n=0, all outputs SHALL be 0 (mem_stall, dmem_*, wb_*, err), asynchronously.
REQ-021 Reset asserted mid-ACCESS SHALL drop dmem_req immediately with no writeback; first accept is on the first clk edge after deassertion.

Structure
REQ-022 Shared package mem_pkg SHALL hold the state enum (IDLE, ACCESS), DATA_W=32 and REG_ADDR_W=5.
REQ-023 The wait counter SHALL be sub-module mem_wait_timer (inputs clear, enable; output expired), width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-024 ADD result: ex_res=0x0000_0011, rd=5, write_reg=1 -> next cycle wb_valid=1, wb_data=0x11, wb_rd=5, wb_en=1, mem_stall=0.
REQ-025 LW: ex_res=0x100, rd=3, ready after 3 cycles with rdata=0xDEAD_BEEF:
- dmem_addr=0x100 and dmem_req held 3 cycles;
- mem_stall high during ACCESS;
- then wb_data=0xDEADBEEF, wb_en=1.
REQ-026 SW: ex_res=0x204, store_data=0x1234, ready immediately -> dmem_we=1, dmem_wdata=0x1234 for 1 cycle, then wb_valid=1, wb_en=0.
REQ-027 Fault cases:
- LW to 0x102 -> no dmem_req, next cycle err=1, wb_valid=1, wb_en=0.
- LW with rd=0 -> wb_en=0.
REQ-028 TIMEOUT_CYCLES=4, ready never asserted -> dmem_req high 4 cycles then low, err pulse, wb_en=0; repeat with ready on cycle 4 -> success, no err.
REQ-029 rst_n pulled low during ACCESS -> dmem_req=0 and mem_stall=0 immediately, no wb_valid; next ADD after release completes normally.
